melody_sequencer: RTL and testbench

//  Scheduler that drives tone_generator: plays a programmable note list or passes live buttons through.

---
 rtl/melody_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_melody_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Plays a host-written note list into tone_generator on a ms-tick timebase, else passes live buttons through.
// All outputs registered: play_start -> LOAD next cycle, first note one cycle later; no backpressure, stop aborts at once.
module melody_sequencer #(
  parameter int SEQ_DEPTH = 16,
  parameter int TICK_DIV  = 100000,
  parameter int DUR_UNIT  = 10,
  parameter int GAP_TICKS = 20,
  localparam int AW       = $clog2(SEQ_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [4:0]    buttons_in,
  input  logic [2:0]    live_vol,
  input  logic          play_start,
  input  logic          play_stop,
  input  logic          loop_en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [13:0]   wr_data,
  output logic [4:0]    tone_buttons,
  output logic [5:0]    tone_switches,
  output logic          tone_enable,
  output logic          busy,
  output logic [AW-1:0] cur_index,
  output logic          done
);

  localparam int unsigned NOTE_MAX = 255 * DUR_UNIT * TICK_DIV;
  localparam int unsigned GAP_CYC  = GAP_TICKS * TICK_DIV;
  localparam int unsigned CNT_MAX  = (NOTE_MAX > GAP_CYC) ? NOTE_MAX : GAP_CYC;
  localparam int CW_RAW            = $clog2(CNT_MAX + 1);
  localparam int CW                = (CW_RAW < 18) ? 18 : CW_RAW;
  localparam logic [13:0] END_MARK = 14'h3800;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [13:0]   r_mem [SEQ_DEPTH];
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]    r_btn, w_btn_nxt;
  logic [5:0]    r_sw, w_sw_nxt;
  logic          r_en, w_en_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;

  logic [13:0]   w_entry;
  logic [2:0]    w_note;
  logic [2:0]    w_vol;
  logic [7:0]    w_dur;
  logic [4:0]    w_note_btn;
  logic [4:0]    w_live_btn;
  logic [CW-1:0] w_note_cyc;
  logic          w_last;

  assign w_entry    = r_mem[r_idx];
  assign w_note     = w_entry[13:11];
  assign w_vol      = w_entry[10:8];
  assign w_dur      = w_entry[7:0];
  assign w_live_btn = buttons_in & (~buttons_in + 5'd1);
  assign w_note_cyc = CW'(w_dur) * CW'(DUR_UNIT * TICK_DIV) - CW'(1);
  assign w_last     = (r_idx == AW'(SEQ_DEPTH - 1));

  always_comb begin
    w_note_btn = 5'd0;
    case (w_note)
      3'd1: w_note_btn = 5'b00001;
      3'd2: w_note_btn = 5'b00010;
      3'd3: w_note_btn = 5'b00100;
      3'd4: w_note_btn = 5'b01000;
      3'd5: w_note_btn = 5'b10000;
      default: w_note_btn = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SEQ_DEPTH; i++) r_mem[i] <= END_MARK;
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_btn   <= '0;
      r_sw    <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_btn   <= w_btn_nxt;
      r_sw    <= w_sw_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_btn_nxt   = r_btn;
    w_sw_nxt    = r_sw;
    w_en_nxt    = r_en;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_btn_nxt  = w_live_btn;
        w_en_nxt   = |buttons_in;
        w_sw_nxt   = {live_vol, 3'b000};
        w_busy_nxt = 1'b0;
        if (play_start && !play_stop) begin
          w_state_nxt = S_LOAD;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_btn_nxt   = '0;
          w_en_nxt    = 1'b0;
        end
      end
      S_LOAD: begin
        if (w_note == 3'd7) begin
          if (loop_en) begin
            w_idx_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end
        end else if (w_dur == 8'd0) begin
          if (w_last && !loop_en) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end
          w_idx_nxt = r_idx + AW'(1);
        end else begin
          w_state_nxt = S_NOTE;
          w_cnt_nxt   = w_note_cyc;
          w_btn_nxt   = w_note_btn;
          w_en_nxt    = |w_note_btn;
          w_sw_nxt    = {w_vol, 3'b000};
        end
      end
      S_NOTE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CW'(GAP_CYC - 1);
          w_btn_nxt   = '0;
          w_en_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_LOAD;
          w_idx_nxt   = r_idx + AW'(1);
          if (w_last && !loop_en) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything: straight back to live pass-through, no done.
    if (r_state != S_IDLE && play_stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_btn_nxt   = w_live_btn;
      w_en_nxt    = |buttons_in;
      w_sw_nxt    = {live_vol, 3'b000};
    end
  end

  assign tone_buttons  = r_btn;
  assign tone_switches = r_sw;
  assign tone_enable   = r_en;
  assign busy          = r_busy;
  assign cur_index     = r_idx;
  assign done          = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with small timing parameters.
module tb_melody_sequencer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] buttons_in;
  logic [2:0] live_vol;
  logic       play_start, play_stop, loop_en, wr_en;
  logic [1:0] wr_addr;
  logic [13:0] wr_data;
  logic [4:0] tone_buttons;
  logic [5:0] tone_switches;
  logic       tone_enable, busy, done;
  logic [1:0] cur_index;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] t_btn  [64];
  logic [5:0] t_sw   [64];
  logic       t_en   [64];
  logic       t_busy [64];
  logic       t_done [64];
  logic [1:0] t_idx  [64];

  typedef struct {
    logic [4:0] btn_in;
    logic [2:0] vol;
    logic [4:0] exp_btn;
    logic [5:0] exp_sw;
    logic       exp_en;
  } live_vec_t;

  live_vec_t live_vecs [5];

  melody_sequencer #(.SEQ_DEPTH(4), .TICK_DIV(4), .DUR_UNIT(1), .GAP_TICKS(2)) dut (
    .clk(clk), .reset_n(reset_n), .buttons_in(buttons_in), .live_vol(live_vol),
    .play_start(play_start), .play_stop(play_stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tone_buttons(tone_buttons), .tone_switches(tone_switches), .tone_enable(tone_enable),
    .busy(busy), .cur_index(cur_index), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [13:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Pulse play_start, then record outputs for cycles k=1..n after it.
  task automatic start_trace(input int n);
    play_start = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) play_start = 1'b0;
      t_btn[k] = tone_buttons; t_sw[k] = tone_switches; t_en[k] = tone_enable;
      t_busy[k] = busy; t_done[k] = done; t_idx[k] = cur_index;
    end
  endtask

  function automatic int count_en(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (t_en[k]) c++;
    return c;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (t_done[k]) c++;
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 1; k <= n; k++) if (t_done[k]) return k;
    return -1;
  endfunction

  initial begin
    live_vecs[0] = '{5'b01100, 3'd5, 5'b00100, 6'b101000, 1'b1};
    live_vecs[1] = '{5'b00000, 3'd3, 5'b00000, 6'b011000, 1'b0};
    live_vecs[2] = '{5'b10000, 3'd7, 5'b10000, 6'b111000, 1'b1};
    live_vecs[3] = '{5'b11111, 3'd0, 5'b00001, 6'b000000, 1'b1};
    live_vecs[4] = '{5'b01010, 3'd2, 5'b00010, 6'b010000, 1'b1};

    reset_n = 1'b0; buttons_in = '0; live_vol = '0; play_start = 0; play_stop = 0;
    loop_en = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    check("rst_btn", 32'(tone_buttons), 0);
    check("rst_sw", 32'(tone_switches), 0);
    check("rst_en", 32'(tone_enable), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_idx", 32'(cur_index), 0);
    check("rst_done", 32'(done), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      buttons_in = live_vecs[i].btn_in;
      live_vol   = live_vecs[i].vol;
      tick();
      check($sformatf("live%0d_btn", i), 32'(tone_buttons), 32'(live_vecs[i].exp_btn));
      check($sformatf("live%0d_sw", i), 32'(tone_switches), 32'(live_vecs[i].exp_sw));
      check($sformatf("live%0d_en", i), 32'(tone_enable), 32'(live_vecs[i].exp_en));
    end
    buttons_in = '0; live_vol = '0;
    tick();

    // DO vol7 dur3, rest vol2 dur1, end marker
    wr(2'd0, 14'h0F03); wr(2'd1, 14'h0201); wr(2'd2, 14'h3800);
    tick();
    start_trace(40);
    check("s1_load_busy", 32'(t_busy[1]), 1);
    check("s1_load_en", 32'(t_en[1]), 0);
    check("s1_do_btn", 32'(t_btn[2]), 32'b00001);
    check("s1_do_sw", 32'(t_sw[2]), 32'b111000);
    check("s1_do_last", 32'(t_en[13]), 1);
    check("s1_gap_en", 32'(t_en[14]), 0);
    check("s1_en_cycles", 32'(count_en(40)), 12);
    check("s1_rest_sw", 32'(t_sw[23]), 32'b010000);
    check("s1_rest_en", 32'(t_en[23]), 0);
    check("s1_rest_idx", 32'(t_idx[23]), 1);
    check("s1_done_at", 32'(first_done(40)), 36);
    check("s1_done_cnt", 32'(count_done(40)), 1);
    check("s1_busy35", 32'(t_busy[35]), 1);
    check("s1_busy36", 32'(t_busy[36]), 0);

    // Loop, with live buttons held that must be ignored while busy
    loop_en = 1'b1; buttons_in = 5'b00010; live_vol = 3'd4;
    tick();
    start_trace(40);
    check("s2_wrap_idx", 32'(t_idx[36]), 0);
    check("s2_wrap_busy", 32'(t_busy[36]), 1);
    check("s2_again_btn", 32'(t_btn[37]), 32'b00001);
    check("s2_no_done", 32'(count_done(40)), 0);
    play_stop = 1'b1;
    tick();
    play_stop = 1'b0;
    check("s2_stop_busy", 32'(busy), 0);
    check("s2_stop_btn", 32'(tone_buttons), 32'b00010);
    check("s2_stop_sw", 32'(tone_switches), 32'b100000);
    check("s2_stop_done", 32'(done), 0);
    tick();
    check("s2_stop_done2", 32'(done), 0);
    play_start = 1'b1; play_stop = 1'b1;
    tick();
    play_start = 1'b0; play_stop = 1'b0;
    check("stop_wins", 32'(busy), 0);
    loop_en = 1'b0; buttons_in = '0; live_vol = '0;
    tick();

    // dur=0 entry skipped without gap
    wr(2'd0, 14'h0000); wr(2'd1, 14'h1C01); wr(2'd2, 14'h3800);
    tick();
    start_trace(20);
    check("s3_skip_en", 32'(t_en[2]), 0);
    check("s3_mi_btn", 32'(t_btn[3]), 32'b00100);
    check("s3_mi_sw", 32'(t_sw[3]), 32'b100000);
    check("s3_mi_idx", 32'(t_idx[3]), 1);
    check("s3_done_at", 32'(first_done(20)), 16);

    // No end marker: list wraps and ends
    wr(2'd0, 14'h0901); wr(2'd1, 14'h1101); wr(2'd2, 14'h1901); wr(2'd3, 14'h2101);
    tick();
    start_trace(60);
    check("s4_fa_btn", 32'(t_btn[41]), 32'b01000);
    check("s4_fa_idx", 32'(t_idx[41]), 3);
    check("s4_done_at", 32'(first_done(60)), 53);
    check("s4_wrap_idx", 32'(t_idx[53]), 0);
    check("s4_busy", 32'(t_busy[53]), 0);

    // Async reset mid-note
    start_trace(3);
    check("s5_in_note", 32'(t_en[3]), 1);
    reset_n = 1'b0;
    #1;
    check("s5_rst_btn", 32'(tone_buttons), 0);
    check("s5_rst_en", 32'(tone_enable), 0);
    check("s5_rst_busy", 32'(busy), 0);
    check("s5_rst_sw", 32'(tone_switches), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    start_trace(3);
    check("s5_load_busy", 32'(t_busy[1]), 1);
    check("s5_end_done", 32'(t_done[2]), 1);
    check("s5_end_busy", 32'(t_busy[2]), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
